// File: rtl/gf2m_pkg.sv
`default_nettype none
// ---- gf2m_pkg : shared sizes, FSM encodings and B-163 constant for the GF(2^m) sequencer ----
// ---- rev 1.0 ----
package gf2m_pkg;

  localparam int DIGITAL_DEFAULT    = 8;
  localparam int DATA_WIDTH_DEFAULT = 163;
  localparam int WD_LIMIT           = 4;

  localparam logic [162:0] G163 = 163'hC9;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  function automatic int num_digits(input int data_width, input int digital);
    return (data_width + digital - 1) / digital;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2m_digit_shifter.sv
`default_nettype none
// ---- gf2m_digit_shifter : parallel-load register shifting one digit left per enable, top digit out ----
// ---- rev 1.0 ----
module gf2m_digit_shifter #(
  parameter int DIGITAL    = 8,
  parameter int NUM_DIGITS = 21
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          shift,
  input  logic [NUM_DIGITS*DIGITAL-1:0] din,
  output logic [DIGITAL-1:0]            top
);

  localparam int WIDTH = NUM_DIGITS * DIGITAL;

  logic [WIDTH-1:0] r_sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
    end else if (load) begin
      r_sreg <= din;
    end else if (shift) begin
      r_sreg <= r_sreg << DIGITAL;
    end
  end

  assign top = r_sreg[WIDTH-1 -: DIGITAL];

endmodule
`default_nettype wire

// File: rtl/gf2m_operand_sequencer.sv
`default_nettype none
// ---- gf2m_operand_sequencer : streams b digits into the gf2m core and returns its product ----
// ---- rev 1.0 ; optional WAIT watchdog enabled by defining GF2M_SEQ_TIMEOUT_EN ----
module gf2m_operand_sequencer
  import gf2m_pkg::*;
#(
  parameter int DIGITAL    = DIGITAL_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_g,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_g,
  output logic [DIGITAL-1:0]    core_b,
  input  logic [DATA_WIDTH-1:0] core_t,
  input  logic                  core_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy,
  output logic                  err
);

  localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGITAL);
  localparam int PAD_WIDTH  = NUM_DIGITS * DIGITAL;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  // The core runs DATA_WIDTH/DIGITAL+1 CAL cycles; only a partial top digit makes that equal NUM_DIGITS.
  generate
    if (DATA_WIDTH % DIGITAL == 0) begin : g_digit_split_check
      $error("gf2m_operand_sequencer: DATA_WIDTH must not be a multiple of DIGITAL");
    end
  endgenerate

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_g;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DIGITAL-1:0]    w_top;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_capture;
  logic                  w_timeout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)                w_next = ST_START;
      ST_START:                              w_next = ST_FEED;
      ST_FEED:  if (r_cnt == LAST_DIGIT)     w_next = ST_WAIT;
      ST_WAIT:  if (core_done || w_timeout)  w_next = ST_OUT;
      ST_OUT:   if (out_ready)               w_next = ST_IDLE;
      default:                               w_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_capture  = 1'b0;
    core_b     = '0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        w_load   = in_valid;
      end
      ST_START: core_start = 1'b1;
      ST_FEED: begin
        core_b  = w_top;
        w_shift = 1'b1;
      end
      ST_WAIT:  w_capture = core_done;
      ST_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_g      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_a <= in_a;
        r_g <= in_g;
      end
      if (r_state == ST_START) begin
        r_cnt <= '0;
      end else if (r_state == ST_FEED) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_result <= core_t;
      end else if (w_timeout) begin
        r_result <= '0;
      end
    end
  end

  gf2m_digit_shifter #(
    .DIGITAL    (DIGITAL),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .din   (PAD_WIDTH'(in_b)),
    .top   (w_top)
  );

`ifdef GF2M_SEQ_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_err;

  // Fires on the WD_LIMIT-th consecutive WAIT cycle without core_done.
  assign w_timeout = (r_state == ST_WAIT) && !core_done && (r_wd == 8'(WD_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && !core_done) begin
        r_wd <= r_wd + 8'd1;
      end else begin
        r_wd <= '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign core_a     = r_a;
  assign core_g     = r_g;
  assign out_result = r_result;

endmodule
`default_nettype wire
